// File: rtl/bus_pkg.sv
// Shared codes, widths, sequencer states and one-hot decoders for the bus transfer scheduler.
package bus_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned NSRC   = 26;
  localparam int unsigned NDST   = 25;

  // Source codes: R0..R15 occupy 0..15
  localparam logic [CODE_W-1:0] SRC_R0    = 5'd0;
  localparam logic [CODE_W-1:0] SRC_HI    = 5'd16;
  localparam logic [CODE_W-1:0] SRC_LO    = 5'd17;
  localparam logic [CODE_W-1:0] SRC_ZHI   = 5'd18;
  localparam logic [CODE_W-1:0] SRC_ZLO   = 5'd19;
  localparam logic [CODE_W-1:0] SRC_PC    = 5'd20;
  localparam logic [CODE_W-1:0] SRC_MDR   = 5'd21;
  localparam logic [CODE_W-1:0] SRC_IN    = 5'd22;
  localparam logic [CODE_W-1:0] SRC_CSIGN = 5'd23;
  localparam logic [CODE_W-1:0] SRC_Y     = 5'd24;
  localparam logic [CODE_W-1:0] SRC_MAR   = 5'd25;

  // Destination codes: R0..R15 occupy 0..15
  localparam logic [CODE_W-1:0] DST_R0  = 5'd0;
  localparam logic [CODE_W-1:0] DST_HI  = 5'd16;
  localparam logic [CODE_W-1:0] DST_LO  = 5'd17;
  localparam logic [CODE_W-1:0] DST_Z   = 5'd18;
  localparam logic [CODE_W-1:0] DST_PC  = 5'd19;
  localparam logic [CODE_W-1:0] DST_MDR = 5'd20;
  localparam logic [CODE_W-1:0] DST_OUT = 5'd21;
  localparam logic [CODE_W-1:0] DST_Y   = 5'd22;
  localparam logic [CODE_W-1:0] DST_MAR = 5'd23;
  localparam logic [CODE_W-1:0] DST_IR  = 5'd24;

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  typedef struct packed {
    logic [CODE_W-1:0] src;
    logic [CODE_W-1:0] dst;
  } xfer_t;

  function automatic logic [NSRC-1:0] src_onehot(input logic [CODE_W-1:0] code);
    return NSRC'(1) << code;
  endfunction

  function automatic logic [NDST-1:0] dst_onehot(input logic [CODE_W-1:0] code);
    return NDST'(1) << code;
  endfunction

endpackage

// File: rtl/xfer_fifo.sv
// Synchronous request FIFO holding (source, destination) transfer pairs.
module xfer_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  xfer_t                    wdata,
  output xfer_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  xfer_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_xfer_scheduler.sv
// Sequences queued register transfers onto the shared bus: one driver per cycle, settle before load.
module bus_xfer_scheduler
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     req_valid,
  input  logic [4:0]               req_src,
  input  logic [4:0]               req_dst,
  output logic                     req_ready,
  input  logic                     hold,
  output logic [NSRC-1:0]          src_en,
  output logic [NDST-1:0]          dst_ld,
  output logic                     xfer_done,
  output logic                     busy,
  output logic                     err_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  state_t state, state_n;
  xfer_t  cur, cur_n, head, req;
  logic   full, empty, legal, accept, start, bypass, push, pop;

  assign req       = '{src: req_src, dst: req_dst};
  assign legal     = (req_src < CODE_W'(NSRC)) && (req_dst < CODE_W'(NDST));
  assign req_ready = ~full;
  assign accept    = req_valid & ~full & legal;

  // A request arriving into an empty FIFO is taken straight into cur so DRIVE follows next cycle
  assign start  = ((state == IDLE) || (state == LOAD)) && !hold && (!empty || accept);
  assign bypass = start & empty;
  assign pop    = start & ~empty;
  assign push   = accept & ~bypass;
  assign busy   = (state != IDLE) || !empty;

  xfer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (req),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_n = state;
    cur_n   = cur;
    case (state)
      IDLE: if (start) begin
        state_n = DRIVE;
        cur_n   = bypass ? req : head;
      end
      DRIVE: if (!hold) state_n = LOAD;
      LOAD: if (start) begin
        state_n = DRIVE;
        cur_n   = bypass ? req : head;
      end else begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Enables are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      cur         <= '0;
      src_en      <= '0;
      dst_ld      <= '0;
      xfer_done   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      src_en      <= (state_n != IDLE) ? src_onehot(cur_n.src) : '0;
      dst_ld      <= (state_n == LOAD) ? dst_onehot(cur_n.dst) : '0;
      xfer_done   <= (state_n == LOAD);
      err_illegal <= req_valid & ~full & ~legal;
    end
  end

endmodule

// File: tb/tb_bus_xfer_scheduler.sv
// Bench for bus_xfer_scheduler: vector table, scoreboard of completed transfers, corner sequences.
module tb_bus_xfer_scheduler;

  logic        clk;
  logic        clear;
  logic        req_valid;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic        req_ready;
  logic        hold;
  logic [25:0] src_en;
  logic [24:0] dst_ld;
  logic        xfer_done;
  logic        busy;
  logic        err_illegal;
  logic [2:0]  count;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [4:0] s;
    logic [4:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0]  src;
    logic [4:0]  dst;
    bit          legal;
    logic [31:0] exp_src;
    logic [31:0] exp_dst;
  } vec_t;
  vec_t vecs[9];

  bus_xfer_scheduler #(.DEPTH(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_src     (req_src),
    .req_dst     (req_dst),
    .req_ready   (req_ready),
    .hold        (hold),
    .src_en      (src_en),
    .dst_ld      (dst_ld),
    .xfer_done   (xfer_done),
    .busy        (busy),
    .err_illegal (err_illegal),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] oh(input logic [4:0] c);
    logic [31:0] one;
    one = 32'd1;
    return one << c;
  endfunction

  function automatic vec_t mk(input logic [4:0] s, input logic [4:0] d, input bit l);
    vec_t v;
    v.src = s;
    v.dst = d;
    v.legal = l;
    v.exp_src = l ? oh(s) : 32'd0;
    v.exp_dst = l ? oh(d) : 32'd0;
    return v;
  endfunction

  task automatic send(input logic [4:0] s, input logic [4:0] d, input bit expect_accept);
    exp_t e;
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    if (expect_accept) begin
      e.s = s;
      e.d = d;
      sb.push_back(e);
    end
  endtask

  // Every completed load must match the oldest accepted request
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!clear && xfer_done) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL sb_unexpected: xfer_done=1 with no pending transfer, expected none");
        end else begin
          e = sb.pop_front();
          check("sb_src_en", 32'(src_en), oh(e.s));
          check("sb_dst_ld", 32'(dst_ld), oh(e.d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!clear) begin
      assert ($onehot0(src_en) && $onehot0(dst_ld))
      else begin
        failed++;
        $display("FAIL onehot: src_en=%0h dst_ld=%0h, expected at most one bit each", src_en, dst_ld);
      end
    end
  end

  initial begin
    vecs[0] = mk(5'd19, 5'd3,  1'b1);
    vecs[1] = mk(5'd25, 5'd23, 1'b1);
    vecs[2] = mk(5'd25, 5'd25, 1'b0);
    vecs[3] = mk(5'd0,  5'd24, 1'b1);
    vecs[4] = mk(5'd24, 5'd0,  1'b1);
    vecs[5] = mk(5'd27, 5'd2,  1'b0);
    vecs[6] = mk(5'd26, 5'd24, 1'b0);
    vecs[7] = mk(5'd31, 5'd31, 1'b0);
    vecs[8] = mk(5'd13, 5'd13, 1'b1);

    clear = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0; hold = 1'b0;
    tick; tick;
    check("rst_src_en", 32'(src_en), 32'd0);
    check("rst_dst_ld", 32'(dst_ld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_xfer_done", 32'(xfer_done), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    clear = 1'b0;
    tick;

    foreach (vecs[i]) begin
      send(vecs[i].src, vecs[i].dst, vecs[i].legal);
      tick;
      req_valid = 1'b0;
      check("vec_c1_src_en", 32'(src_en), vecs[i].exp_src);
      check("vec_c1_dst_ld", 32'(dst_ld), 32'd0);
      check("vec_c1_err", 32'(err_illegal), 32'(!vecs[i].legal));
      check("vec_c1_count", 32'(count), 32'd0);
      check("vec_c1_busy", 32'(busy), 32'(vecs[i].legal));
      tick;
      check("vec_c2_src_en", 32'(src_en), vecs[i].exp_src);
      check("vec_c2_dst_ld", 32'(dst_ld), vecs[i].exp_dst);
      check("vec_c2_done", 32'(xfer_done), 32'(vecs[i].legal));
      check("vec_c2_err", 32'(err_illegal), 32'd0);
      tick;
      check("vec_c3_src_en", 32'(src_en), 32'd0);
      check("vec_c3_dst_ld", 32'(dst_ld), 32'd0);
      check("vec_c3_done", 32'(xfer_done), 32'd0);
      check("vec_c3_busy", 32'(busy), 32'd0);
    end

    // Fill under hold: fifth request refused, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(5'(i + 1), 5'(i + 10), i < 4);
      if (i == 4) begin
        check("fill_req_ready", 32'(req_ready), 32'd0);
        check("fill_count", 32'(count), 32'd4);
      end
      tick;
    end
    req_valid = 1'b0;
    check("fill_count_after", 32'(count), 32'd4);
    check("fill_src_idle", 32'(src_en), 32'd0);
    check("fill_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      check("drain_done", 32'(xfer_done), 32'(k % 2));
      if (k % 2 == 0) begin
        check("drain_src_en", 32'(src_en), oh(5'(k / 2 + 1)));
        check("drain_dst_ld", 32'(dst_ld), 32'd0);
      end
    end
    tick;
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Hold in DRIVE for three cycles, then hold during LOAD
    send(5'd21, 5'd20, 1'b1);
    tick;
    req_valid = 1'b0;
    hold = 1'b1;
    check("hold_drive_src", 32'(src_en), oh(5'd21));
    for (int k = 0; k < 3; k++) begin
      tick;
      check("hold_src_stable", 32'(src_en), oh(5'd21));
      check("hold_no_load", 32'(dst_ld), 32'd0);
      check("hold_no_done", 32'(xfer_done), 32'd0);
    end
    hold = 1'b0;
    send(5'd22, 5'd21, 1'b1);
    tick;
    check("hold_load_dst", 32'(dst_ld), oh(5'd20));
    check("hold_load_done", 32'(xfer_done), 32'd1);
    req_valid = 1'b0;
    hold = 1'b1;
    tick;
    check("hold_after_load_src", 32'(src_en), 32'd0);
    check("hold_after_load_done", 32'(xfer_done), 32'd0);
    check("hold_after_load_count", 32'(count), 32'd1);
    check("hold_after_load_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    tick;
    check("hold2_drive_src", 32'(src_en), oh(5'd22));
    check("hold2_drive_dst", 32'(dst_ld), 32'd0);
    tick;
    check("hold2_load_dst", 32'(dst_ld), oh(5'd21));
    tick;
    check("hold2_busy", 32'(busy), 32'd0);

    // Asynchronous clear in the middle of DRIVE with a queued request
    send(5'd10, 5'd7, 1'b1);
    tick;
    hold = 1'b1;
    send(5'd11, 5'd8, 1'b1);
    tick;
    req_valid = 1'b0;
    check("clr_pre_count", 32'(count), 32'd1);
    check("clr_pre_src", 32'(src_en), oh(5'd10));
    #1 clear = 1'b1;
    #1;
    check("clr_src_en", 32'(src_en), 32'd0);
    check("clr_dst_ld", 32'(dst_ld), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_req_ready", 32'(req_ready), 32'd1);
    sb.delete();
    tick;
    clear = 1'b0;
    hold = 1'b0;
    tick;
    tick;
    check("clr_post_busy", 32'(busy), 32'd0);
    check("clr_post_done", 32'(xfer_done), 32'd0);
    check("clr_post_src", 32'(src_en), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
